ldtu_word_decoder: RTL and testbench

Receive-side decoder for the LiTE-DTU 32-bit output word stream. It sits after the deserializer in the back-end and in the verification environment. It classifies each incoming 32-bit word, unpacks baseline and signal words into a stream of 13-bit samples (gain flag plus 12-bit data), and drops idle words. Frame trailers are checked against a local sample count, and malformed words are reported.

---
 rtl/ldtu_word_decoder.sv | 155 +++++++++++++++
 tb/tb_ldtu_word_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_word_decoder.sv
// LiTE-DTU receive-side word decoder: classifies 32-bit DTU words and unpacks them into 13-bit samples.
// Optional trailer/frame checking is enabled by defining LDTU_DEC_FRAMECHECK_EN.
`timescale 1ns/1ps

module ldtu_word_decoder #(
    parameter int                  Nbits_32     = 32,
    parameter int                  Nbits_12     = 12,
    parameter logic [Nbits_32-1:0] IDLE_PATTERN = 32'hEAAAAAAA
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Nbits_32-1:0] word_in,
    input  logic                word_valid,
    output logic                word_ready,
    output logic [Nbits_12:0]   sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                frame_done,
    output logic [11:0]         frame_num,
    output logic                frame_err,
    output logic                fmt_err
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] EMIT  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       idx;
    logic [2:0]       remaining;
    logic [Nbits_12:0] hold [5];

    logic [Nbits_12:0] dec_samp [5];
    logic [2:0]        dec_n;
    logic              dec_bad;
`ifdef LDTU_DEC_FRAMECHECK_EN
    logic              dec_trl;
`endif

    logic accept;
    logic hs;
    logic load;
    logic last;

    // Word classification; baseline and partial-baseline share the 6-bit field layout.
    always_comb begin
        dec_n   = 3'd0;
        dec_bad = 1'b0;
`ifdef LDTU_DEC_FRAMECHECK_EN
        dec_trl = 1'b0;
`endif
        for (int k = 0; k < 5; k++) begin
            dec_samp[k] = {{(Nbits_12-5){1'b0}}, word_in[6*k +: 6]};
        end
        if (word_in == IDLE_PATTERN) begin
            dec_n = 3'd0;
        end else if (word_in[31:30] == 2'b01) begin
            dec_n = 3'd5;
        end else if (word_in[31:28] == 4'b1000) begin
            if (word_in[27:25] >= 3'd1 && word_in[27:25] <= 3'd4) begin
                dec_n = word_in[27:25];
            end else begin
                dec_bad = 1'b1;
            end
        end else if (word_in[31:26] == 6'b001010) begin
            dec_n       = 3'd2;
            dec_samp[0] = word_in[Nbits_12:0];
            dec_samp[1] = word_in[2*Nbits_12+1:Nbits_12+1];
        end else if (word_in[31:26] == 6'b001011) begin
            dec_n       = 3'd1;
            dec_samp[0] = word_in[Nbits_12:0];
        end else if (word_in[31:28] == 4'b1101) begin
`ifdef LDTU_DEC_FRAMECHECK_EN
            dec_trl = 1'b1;
`endif
        end else begin
            dec_bad = 1'b1;
        end
    end

    // NOTE: word_ready is combinational from sample_ready so a new word can be taken on the last sample's handshake.
    assign word_ready   = ~RST & ((state == EMPTY) | ((remaining == 3'd1) & sample_ready));
    assign accept       = word_valid & word_ready;
    assign hs           = (state == EMIT) & sample_ready;
    assign load         = accept & (dec_n != 3'd0);
    assign last         = hs & (remaining == 3'd1);
    assign sample_valid = (state == EMIT);
    assign sample_out   = (state == EMIT) ? hold[idx] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            idx       <= 3'd0;
            remaining <= 3'd0;
        end else if (load) begin
            state     <= EMIT;
            idx       <= 3'd0;
            remaining <= dec_n;
        end else if (hs) begin
            remaining <= remaining - 3'd1;
            if (last) begin
                state <= EMPTY;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    // NOTE: the holding register has no reset; it is only observed through sample_out while state is EMIT.
    always_ff @(posedge CLK) begin
        if (load) begin
            hold <= dec_samp;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fmt_err <= 1'b0;
        end else begin
            fmt_err <= accept & dec_bad;
        end
    end

`ifdef LDTU_DEC_FRAMECHECK_EN
    logic [7:0] frame_cnt;
    logic [7:0] cnt_next;

    // A handshake in the trailer's cycle belongs to the frame being closed.
    assign cnt_next = frame_cnt + {7'd0, hs};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt  <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_num  <= 12'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (accept & dec_trl) begin
                frame_done <= 1'b1;
                frame_num  <= word_in[19:8];
                frame_err  <= (word_in[7:0] != cnt_next);
                frame_cnt  <= 8'd0;
            end else begin
                frame_cnt <= cnt_next;
            end
        end
    end
`else
    assign frame_done = 1'b0;
    assign frame_err  = 1'b0;
    assign frame_num  = 12'd0;
`endif

endmodule

// File: tb/tb_ldtu_word_decoder.sv
// Self-checking bench for ldtu_word_decoder: queue-based reference model plus directed word sequences.
// Works with LDTU_DEC_FRAMECHECK_EN either defined or undefined.
`timescale 1ns/1ps

module tb_ldtu_word_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [12:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        frame_done;
    logic [11:0] frame_num;
    logic        frame_err;
    logic        fmt_err;

    ldtu_word_decoder dut (
        .CLK          (CLK),
        .RST          (RST),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_done   (frame_done),
        .frame_num    (frame_num),
        .frame_err    (frame_err),
        .fmt_err      (fmt_err)
    );

    always #5 CLK = ~CLK;

`ifdef LDTU_DEC_FRAMECHECK_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // kind: 0 = sample word, 1 = dropped, 2 = trailer, 3 = malformed
    function automatic void model_decode(input logic [31:0] w, output int n,
                                         output logic [12:0] s[5], output int kind);
        int m;
        n    = 0;
        kind = 0;
        for (int k = 0; k < 5; k++) s[k] = 13'd0;
        m = int'((w >> 25) & 32'h7);
        if (w == 32'hEAAAAAAA) begin
            kind = 1;
        end else if (w[31:30] == 2'b01) begin
            n = 5;
            for (int k = 0; k < 5; k++) s[k] = 13'((w >> (6*k)) & 32'h3F);
        end else if (w[31:28] == 4'h8) begin
            if (m >= 1 && m <= 4) begin
                n = m;
                for (int k = 0; k < 5; k++) s[k] = (k < m) ? 13'((w >> (6*k)) & 32'h3F) : 13'd0;
            end else begin
                kind = 3;
            end
        end else if (w[31:26] == 6'b001010) begin
            n    = 2;
            s[0] = 13'(w & 32'h1FFF);
            s[1] = 13'((w >> 13) & 32'h1FFF);
        end else if (w[31:26] == 6'b001011) begin
            n    = 1;
            s[0] = 13'(w & 32'h1FFF);
        end else if (w[31:28] == 4'hD) begin
            kind = FC_EN ? 2 : 1;
        end else begin
            kind = 3;
        end
    endfunction

    // Reference model state
    logic [12:0] q[$];
    int          fc = 0;
    logic        e_done = 1'b0, e_ferr = 1'b0, e_fmt = 1'b0;
    logic [11:0] e_num = 12'd0;
    int cnt_done = 0, cnt_ferr = 0, cnt_fmt = 0, cnt_hs = 0;

    always @(negedge CLK) begin
        logic        exp_wr, hs, acc;
        int          n, kind, fc_next;
        logic [12:0] s[5];
        if (RST) begin
            check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
            check("rst_sample_out", {19'd0, sample_out}, 32'd0);
            check("rst_word_ready", {31'd0, word_ready}, 32'd0);
            check("rst_frame_done", {31'd0, frame_done}, 32'd0);
            check("rst_frame_err", {31'd0, frame_err}, 32'd0);
            check("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
            check("rst_frame_num", {20'd0, frame_num}, 32'd0);
            q.delete();
            fc     = 0;
            e_done = 1'b0;
            e_ferr = 1'b0;
            e_fmt  = 1'b0;
            e_num  = 12'd0;
        end else begin
            exp_wr = (q.size() == 0) || (q.size() == 1 && sample_ready);
            check("sample_valid", {31'd0, sample_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) check("sample_out", {19'd0, sample_out}, {19'd0, q[0]});
            check("word_ready", {31'd0, word_ready}, {31'd0, exp_wr});
            check("fmt_err", {31'd0, fmt_err}, {31'd0, e_fmt});
            check("frame_done", {31'd0, frame_done}, {31'd0, e_done});
            check("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
            check("frame_num", {20'd0, frame_num}, {20'd0, e_num});
            if (frame_done) cnt_done++;
            if (frame_err) cnt_ferr++;
            if (fmt_err) cnt_fmt++;
            if (sample_valid && sample_ready) cnt_hs++;

            hs     = (q.size() != 0) && sample_ready;
            acc    = word_valid && exp_wr;
            e_done = 1'b0;
            e_ferr = 1'b0;
            e_fmt  = 1'b0;
            if (hs) void'(q.pop_front());
            fc_next = fc + (hs ? 1 : 0);
            fc      = fc_next % 256;
            if (acc) begin
                model_decode(word_in, n, s, kind);
                for (int k = 0; k < n; k++) q.push_back(s[k]);
                if (kind == 3) e_fmt = 1'b1;
                if (kind == 2) begin
                    e_done = 1'b1;
                    e_num  = word_in[19:8];
                    e_ferr = (fc_next % 256) != int'(word_in[7:0]);
                    fc     = 0;
                end
            end
        end
    end

    // 0: always ready, 1: toggle every cycle
    int sr_mode = 0;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sr_mode == 1) sample_ready = ~sample_ready;
            else sample_ready = 1'b1;
        end
    end

    task automatic send(input logic [31:0] w);
        bit ok;
        ok         = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            if (word_ready) ok = 1'b1;
        end
        @(posedge CLK);
        #1;
        word_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: word %0h not accepted within 100 cycles", w);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] w_sig2;
    int          pn, pkind;
    logic [12:0] ps[5];
    int          hs0, done0, ferr0, fmt0;

    initial begin
        w_sig2 = {6'b001010, 13'h1ABC, 13'h0123};

        // Pin the reference decoder with hand-computed values.
        model_decode(32'h41083105, pn, ps, pkind);
        check("pin_base_n", pn, 5);
        check("pin_base_s0", {19'd0, ps[0]}, 32'h005);
        check("pin_base_s4", {19'd0, ps[4]}, 32'h001);
        model_decode(32'h86033891, pn, ps, pkind);
        check("pin_part_n", pn, 3);
        check("pin_part_s2", {19'd0, ps[2]}, 32'h033);
        model_decode(w_sig2, pn, ps, pkind);
        check("pin_sig_s0", {19'd0, ps[0]}, 32'h0123);
        check("pin_sig_s1", {19'd0, ps[1]}, 32'h1ABC);

        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Baseline word: samples 5..1 on consecutive cycles, latency 1.
        send(32'h41083105);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("base_seq_valid", {31'd0, sample_valid}, 32'd1);
            check("base_seq_out", {19'd0, sample_out}, 32'(5 - i));
        end
        drain();

        // Signal word with stalls.
        sr_mode = 1;
        hs0 = cnt_hs;
        send(w_sig2);
        drain();
        sr_mode = 0;
        check("sig_hs_count", cnt_hs - hs0, 2);

        // Close the current 7-sample frame.
        done0 = cnt_done; ferr0 = cnt_ferr;
        send(32'hD0000107);
        drain();
`ifdef LDTU_DEC_FRAMECHECK_EN
        check("sync_done", cnt_done - done0, 1);
        check("sync_ferr", cnt_ferr - ferr0, 0);
`endif

        // Back-to-back stream ending with a good trailer.
        hs0 = cnt_hs; done0 = cnt_done; ferr0 = cnt_ferr;
        send(32'h2C000ABC);
        send(32'h86033891);
        send(32'hEAAAAAAA);
        send(32'hD0005A04);
        drain();
        check("stream_hs_count", cnt_hs - hs0, 4);
`ifdef LDTU_DEC_FRAMECHECK_EN
        check("stream_done", cnt_done - done0, 1);
        check("stream_num", {20'd0, frame_num}, 32'h05A);
        check("stream_ferr", cnt_ferr - ferr0, 0);
`else
        check("stream_done_off", cnt_done - done0, 0);
        check("stream_num_off", {20'd0, frame_num}, 32'h0);
`endif

        // Wrong count, then a trailer taken alongside the last handshake.
        ferr0 = cnt_ferr; done0 = cnt_done;
        send(32'h2C000ABC);
        send(32'h86033891);
        send(32'hD0000107);
        drain();
        send(32'h2C000111);
        send(32'hD0000201);
        drain();
`ifdef LDTU_DEC_FRAMECHECK_EN
        check("err_ferr", cnt_ferr - ferr0, 1);
        check("err_done", cnt_done - done0, 2);
        check("same_cycle_num", {20'd0, frame_num}, 32'h002);
`else
        check("err_ferr_off", cnt_ferr - ferr0, 0);
`endif

        // Malformed words.
        fmt0 = cnt_fmt; hs0 = cnt_hs;
        send(32'hF0000000);
        send(32'h80000000);
        send(32'h8A000000);
        drain();
        check("fmt_count", cnt_fmt - fmt0, 3);
        check("fmt_no_samples", cnt_hs - hs0, 0);

        // Reset in mid-word.
        send(32'h41083105);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("arst_valid", {31'd0, sample_valid}, 32'd0);
        check("arst_out", {19'd0, sample_out}, 32'd0);
        check("arst_ready", {31'd0, word_ready}, 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
        send(32'h41083105);
        @(negedge CLK);
        check("post_rst_s0", {19'd0, sample_out}, 32'h005);
        drain();

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
